pc_fetch_sequencer: RTL and testbench

//  Owns the architectural PC register and sequences instruction fetch around the combinational pc+4 adder.

---
 rtl/pc_fetch_sequencer_if.sv | 11 +
 rtl/pc_fetch_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory fetch bus between the PC sequencer and imem.
// Latency: none, plain wires.
// Backpressure: req is held with a stable addr until ack returns.
interface pc_fetch_sequencer_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;

  modport master (output req, output addr, input ack);
  modport slave  (input req, input addr, output ack);
endinterface

// File: rtl/pc_fetch_sequencer.sv
// PC register and fetch sequencer: issues imem fetches, arbitrates redirects (exc > jmp > br > seq).
// Latency: one instruction per cycle with back-to-back acks; if_valid/flush/misalign are registered (next cycle).
// Backpressure: stall parks the FSM in HOLD (req low); a fetch waits for ack, timing out into ERR.
// Optional feature macro PC_ALIGN_CHECK_EN: misaligned jmp/br targets become exceptions to EXC_VECTOR.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0180,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall,
  input  logic                         br_taken,
  input  logic [31:0]                  br_target,
  input  logic                         jmp_en,
  input  logic [31:0]                  jmp_target,
  input  logic                         exc_en,
  pc_fetch_sequencer_if.master         imem,
  output logic [31:0]                  pc,
  output logic [31:0]                  pc_plus4,
  output logic                         if_valid,
  output logic                         flush,
  output logic                         fetch_err,
  output logic                         misalign
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERR} state_t;

  // Redirect priorities; zero means "nothing pending".
  localparam logic [1:0] PRI_NONE = 2'd0;
  localparam logic [1:0] PRI_BR   = 2'd1;
  localparam logic [1:0] PRI_JMP  = 2'd2;
  localparam logic [1:0] PRI_EXC  = 2'd3;
  localparam logic [7:0] TIMER_LAST = 8'(FETCH_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [31:0] pc_nxt;
  logic [1:0]  pend_pri;
  logic [31:0] pend_tgt;
  logic [7:0]  timer, timer_nxt;
  logic        pend_clr;
  logic        ack_ok;

  logic [1:0]  req_pri;
  logic [31:0] req_tgt;
  logic        req_mis;
  logic        capture;
  logic [1:0]  eff_pri;
  logic [31:0] eff_tgt;
  logic        eff_vld;

  assign pc_plus4 = pc + 32'd4;

  // Pick this cycle's highest-priority redirect request and normalise its target.
  always_comb begin
    req_pri = PRI_NONE;
    req_tgt = 32'h0;
    req_mis = 1'b0;
    if (exc_en) begin
      req_pri = PRI_EXC;
      req_tgt = EXC_VECTOR;
    end else if (jmp_en) begin
      req_pri = PRI_JMP;
      req_tgt = jmp_target;
    end else if (br_taken) begin
      req_pri = PRI_BR;
      req_tgt = br_target;
    end
`ifdef PC_ALIGN_CHECK_EN
    if ((req_pri == PRI_JMP || req_pri == PRI_BR) && req_tgt[1:0] != 2'b00) begin
      req_pri = PRI_EXC;
      req_tgt = EXC_VECTOR;
      req_mis = 1'b1;
    end
`else
    req_tgt[1:0] = 2'b00;
`endif
  end

  // A request wins only over a strictly lower pending one; a same-cycle winner counts as already pending.
  assign capture = (state != ERR) && (req_pri > pend_pri);
  assign eff_pri = capture ? req_pri : pend_pri;
  assign eff_tgt = capture ? req_tgt : pend_tgt;
  assign eff_vld = (eff_pri != PRI_NONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and next-PC decisions.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    pend_clr  = 1'b0;
    ack_ok    = 1'b0;
    timer_nxt = 8'd0;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        if (imem.ack) begin
          // Data fetched while a redirect is outstanding belongs to a killed path.
          ack_ok = !eff_vld;
          if (eff_vld) begin
            pc_nxt   = eff_tgt;
            pend_clr = 1'b1;
          end else if (!stall) begin
            pc_nxt = pc_plus4;
          end else begin
            state_nxt = HOLD;
          end
        end else if (timer == TIMER_LAST) begin
          state_nxt = ERR;
          pend_clr  = 1'b1;
        end else begin
          timer_nxt = timer + 8'd1;
        end
      end
      HOLD: begin
        if (eff_vld) begin
          pc_nxt    = eff_tgt;
          pend_clr  = 1'b1;
          state_nxt = FETCH;
        end else if (!stall) begin
          pc_nxt    = pc_plus4;
          state_nxt = FETCH;
        end
      end
      ERR: begin
        if (exc_en) begin
          pc_nxt    = EXC_VECTOR;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs: request only while fetching, error flag sticky for the whole ERR stay.
  always_comb begin
    imem.req  = (state == FETCH);
    imem.addr = pc;
    fetch_err = (state == ERR);
  end

  // PC, pending redirect, timeout timer and one-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      pend_pri <= PRI_NONE;
      pend_tgt <= 32'h0;
      timer    <= 8'd0;
      if_valid <= 1'b0;
      flush    <= 1'b0;
    end else begin
      pc       <= pc_nxt;
      timer    <= timer_nxt;
      if_valid <= ack_ok;
      flush    <= capture;
      if (pend_clr) begin
        pend_pri <= PRI_NONE;
      end else if (capture) begin
        pend_pri <= req_pri;
        pend_tgt <= req_tgt;
      end
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  // Misalign pulses alongside the flush of the converted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign <= 1'b0;
    else        misalign <= capture & req_mis;
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: sequential fetch, stall, redirects, timeout, alignment, wrap, reset.
// Latency: outputs checked 1ns after each rising edge.
// Backpressure: ack driven directly by the stimulus sequence.
module tb_pc_fetch_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, br_taken, jmp_en, exc_en;
  logic [31:0] br_target, jmp_target;
  logic [31:0] pc, pc_plus4;
  logic        if_valid, flush, fetch_err, misalign;
  int          n_tests = 0;
  int          n_fail  = 0;

  pc_fetch_sequencer_if imem_bus ();

  pc_fetch_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp_en     (jmp_en),
    .jmp_target (jmp_target),
    .exc_en     (exc_en),
    .imem       (imem_bus.master),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .if_valid   (if_valid),
    .flush      (flush),
    .fetch_err  (fetch_err),
    .misalign   (misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; br_taken = 1'b0; jmp_en = 1'b0; exc_en = 1'b0;
    br_target = 32'h0; jmp_target = 32'h0; imem_bus.ack = 1'b0;
    #3;
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);
    chk("rst_req", {31'b0, imem_bus.req}, 32'h0);
    chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_flush", {31'b0, flush}, 32'h0);
    chk("rst_fetch_err", {31'b0, fetch_err}, 32'h0);
    chk("rst_misalign", {31'b0, misalign}, 32'h0);
    tick();
    rst_n = 1'b1;

    // Sequential fetch, one per cycle.
    tick();
    chk("first_req", {31'b0, imem_bus.req}, 32'h1);
    chk("first_addr", imem_bus.addr, 32'h0);
    imem_bus.ack = 1'b1;
    tick();
    chk("seq_addr4", imem_bus.addr, 32'h4);
    chk("seq_ifv4", {31'b0, if_valid}, 32'h1);
    tick();
    chk("seq_addr8", imem_bus.addr, 32'h8);
    chk("seq_ifv8", {31'b0, if_valid}, 32'h1);

    // Stall for three cycles at pc=0x8.
    stall = 1'b1;
    tick();
    chk("hold_pc_a", pc, 32'h8);
    chk("hold_req_a", {31'b0, imem_bus.req}, 32'h0);
    chk("hold_ifv_a", {31'b0, if_valid}, 32'h1);
    imem_bus.ack = 1'b0;
    tick();
    chk("hold_pc_b", pc, 32'h8);
    chk("hold_ifv_b", {31'b0, if_valid}, 32'h0);
    tick();
    chk("hold_pc_c", pc, 32'h8);
    chk("hold_req_c", {31'b0, imem_bus.req}, 32'h0);
    stall = 1'b0;
    tick();
    chk("resume_addr", imem_bus.addr, 32'hC);
    chk("resume_req", {31'b0, imem_bus.req}, 32'h1);
    imem_bus.ack = 1'b1;
    tick();
    chk("seq_addr10", imem_bus.addr, 32'h10);
    chk("seq_ifv10", {31'b0, if_valid}, 32'h1);

    // Branch during a delayed ack.
    imem_bus.ack = 1'b0; br_taken = 1'b1; br_target = 32'h100;
    tick();
    chk("br_flush", {31'b0, flush}, 32'h1);
    chk("br_addr_held", imem_bus.addr, 32'h10);
    chk("br_req_held", {31'b0, imem_bus.req}, 32'h1);
    br_taken = 1'b0;
    tick();
    chk("br_flush_once", {31'b0, flush}, 32'h0);
    imem_bus.ack = 1'b1;
    tick();
    chk("br_addr", imem_bus.addr, 32'h100);
    chk("br_stale_ifv", {31'b0, if_valid}, 32'h0);
    tick();
    chk("br_next_addr", imem_bus.addr, 32'h104);

    // Simultaneous exc/jmp/br, then a lower-priority jmp while exc pending.
    imem_bus.ack = 1'b0; exc_en = 1'b1; jmp_en = 1'b1; jmp_target = 32'h200;
    br_taken = 1'b1; br_target = 32'h300;
    tick();
    chk("prio_flush", {31'b0, flush}, 32'h1);
    chk("prio_pc_held", pc, 32'h104);
    exc_en = 1'b0; br_taken = 1'b0; jmp_en = 1'b1; jmp_target = 32'h200;
    tick();
    chk("prio_ignored_flush", {31'b0, flush}, 32'h0);
    jmp_en = 1'b0; imem_bus.ack = 1'b1;
    tick();
    chk("prio_pc_exc", pc, 32'h180);
    chk("prio_ifv", {31'b0, if_valid}, 32'h0);
    tick();
    chk("exc_next_pc", pc, 32'h184);

    // Fetch timeout.
    imem_bus.ack = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("to_req_last", {31'b0, imem_bus.req}, 32'h1);
    chk("to_err_last", {31'b0, fetch_err}, 32'h0);
    tick();
    chk("to_err", {31'b0, fetch_err}, 32'h1);
    chk("to_req", {31'b0, imem_bus.req}, 32'h0);
    jmp_en = 1'b1; jmp_target = 32'h400;
    tick();
    chk("err_jmp_flush", {31'b0, flush}, 32'h0);
    chk("err_sticky", {31'b0, fetch_err}, 32'h1);
    chk("err_pc", pc, 32'h184);
    jmp_en = 1'b0; exc_en = 1'b1;
    tick();
    chk("err_exit_pc", pc, 32'h180);
    chk("err_exit_flag", {31'b0, fetch_err}, 32'h0);
    chk("err_exit_req", {31'b0, imem_bus.req}, 32'h1);

    // Misaligned jump target.
    exc_en = 1'b0; jmp_en = 1'b1; jmp_target = 32'h202;
    tick();
    chk("mis_flush", {31'b0, flush}, 32'h1);
`ifdef PC_ALIGN_CHECK_EN
    chk("mis_pulse", {31'b0, misalign}, 32'h1);
`else
    chk("mis_pulse", {31'b0, misalign}, 32'h0);
`endif
    jmp_en = 1'b0; imem_bus.ack = 1'b1;
    tick();
`ifdef PC_ALIGN_CHECK_EN
    chk("mis_pc", pc, 32'h180);
`else
    chk("mis_pc", pc, 32'h200);
`endif
    chk("mis_pulse_gone", {31'b0, misalign}, 32'h0);

    // pc+4 wrap at the top of the address space.
    imem_bus.ack = 1'b0; jmp_en = 1'b1; jmp_target = 32'hFFFF_FFFC;
    tick();
    jmp_en = 1'b0; imem_bus.ack = 1'b1;
    tick();
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4, 32'h0);
    tick();
    chk("wrap_pc_next", pc, 32'h0);
    chk("wrap_ifv", {31'b0, if_valid}, 32'h1);
    tick();
    chk("wrap_pc_4", pc, 32'h4);

    // Reset asserted mid-fetch drops req without waiting for a clock edge.
    imem_bus.ack = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_req", {31'b0, imem_bus.req}, 32'h0);
    chk("arst_pc", pc, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
